// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with skid buffer and branch discard
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] Instruction,
    output logic        inst_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SKID = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_out_q, pc_out_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic [31:0] skid_data_q, skid_data_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic        discard_q, discard_d;
    logic [31:0] target_q, target_d;

    logic [31:0] pc_plus4;
    logic        xfer;

    assign imem_req    = (state_q == REQ);
    assign imem_addr   = pc_q;
    assign xfer        = imem_req && imem_ready;
    assign pc_plus4    = pc_q + 32'd4;
    assign PC_out      = pc_out_q;
    assign Instruction = instr_q;
    assign inst_valid  = valid_q;

    // Next-state and datapath: hold everything by default, then apply the
    // branch redirect (which beats freeze), discard completion, or transfer.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pc_out_d    = pc_out_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        skid_data_d = skid_data_q;
        skid_pc_d   = skid_pc_q;
        discard_d   = discard_q;
        target_d    = target_q;

        if (branch_taken) begin
            instr_d  = 32'd0;
            pc_out_d = 32'd0;
            valid_d  = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
                if (branch_taken) begin
                    pc_d = branch_addr;
                end
            end
            REQ: begin
                if (branch_taken) begin
                    if (xfer) begin
                        // Data in flight is dropped; redirect immediately.
                        pc_d      = branch_addr;
                        discard_d = 1'b0;
                    end else begin
                        // Request must complete at its address before redirect.
                        discard_d = 1'b1;
                        target_d  = branch_addr;
                    end
                end else if (discard_q) begin
                    if (xfer) begin
                        pc_d      = target_q;
                        discard_d = 1'b0;
                        valid_d   = 1'b0;
                    end
                end else if (xfer) begin
                    pc_d = pc_plus4;
                    if (freeze) begin
                        skid_data_d = imem_rdata;
                        skid_pc_d   = pc_plus4;
                        state_d     = SKID;
                    end else begin
                        instr_d  = imem_rdata;
                        pc_out_d = pc_plus4;
                        valid_d  = 1'b1;
                    end
                end
            end
            SKID: begin
                if (branch_taken) begin
                    pc_d    = branch_addr;
                    state_d = REQ;
                end else if (!freeze) begin
                    instr_d  = skid_data_q;
                    pc_out_d = skid_pc_q;
                    valid_d  = 1'b1;
                    state_d  = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset that abandons any request in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            pc_out_q    <= 32'd0;
            instr_q     <= 32'd0;
            valid_q     <= 1'b0;
            skid_data_q <= 32'd0;
            skid_pc_q   <= 32'd0;
            discard_q   <= 1'b0;
            target_q    <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pc_out_q    <= pc_out_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            skid_data_q <= skid_data_d;
            skid_pc_q   <= skid_pc_d;
            discard_q   <= discard_d;
            target_q    <= target_d;
        end
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 freeze  input  1  hazard stall from decode; while high, output registers hold.
REQ-005 branch_taken  input  1  redirect request from decode; single-cycle pulse.
REQ-006 branch_addr  input  32  redirect target, sampled when branch_taken=1.
REQ-007 imem_req  output  1  instruction memory request.
REQ-008 imem_addr  output  32  byte address of the requested instruction.
REQ-009 imem_ready  input  1  memory accept; imem_rdata is valid in the same cycle.
REQ-010 imem_rdata  input  32  fetched instruction word.
REQ-011 PC_out  output  32  registered PC+4 of the instruction presented to decode.
REQ-012 Instruction  output  32  registered instruction presented to decode.
REQ-013 inst_valid  output  1  Instruction/PC_out hold a real instruction.

Function
REQ-014 FSM states SHALL be IDLE, REQ and SKID; no other states.
REQ-015 A transfer SHALL occur in any cycle with imem_req=1 and imem_ready=1.
REQ-016 IDLE: imem_req=0; SHALL go to REQ on the next cycle.
REQ-017 REQ: imem_req=1 and imem_addr=PC; imem_addr SHALL stay stable until a transfer.
REQ-018 REQ, transfer with freeze=0 and no discard: Instruction<=imem_rdata, PC_out<=PC+4, inst_valid<=1, PC<=PC+4; stay in REQ (one instruction per cycle throughput).
REQ-019 REQ, transfer with freeze=1: rdata and PC+4 SHALL be captured into a one-entry skid buffer, PC<=PC+4, go to SKID; outputs hold.
REQ-020 SKID: imem_req=0; when freeze=0, skid contents SHALL move to Instruction/PC_out with inst_valid<=1 and go to REQ.
REQ-021 freeze=1 with no transfer: outputs and PC hold; requesting continues.
REQ-022 PC arithmetic SHALL be 32-bit modulo 2^32; 32'hFFFF_FFFC+4 wraps to 0.
REQ-023 branch_taken SHALL override freeze: Instruction<=0, PC_out<=0, inst_valid<=0 in the following cycle.
REQ-024 Branch in REQ with no transfer in the same cycle: set discard flag and latch branch_addr; the pending request SHALL complete at its original address, its data SHALL be dropped, then PC<=latched target, flag cleared, stay in REQ.
REQ-025 Branch in REQ coinciding with a transfer: the data SHALL be dropped and PC<=branch_addr.
REQ-026 Branch in SKID: the skid entry SHALL be discarded, PC<=branch_addr, go to REQ.
REQ-027 Branch in IDLE: PC<=branch_addr.
REQ-028 A second branch_taken while the discard flag is set SHALL overwrite the latched target.
REQ-029 The discard flag being set SHALL suppress inst_valid for the dropped transfer.

Reset
REQ-030 rst=1 SHALL force PC=RESET_PC, state=IDLE, PC_out=0, Instruction=0, inst_valid=0, imem_req=0, skid empty, discard flag clear, on the next edge.
REQ-031 rst SHALL take priority over branch_taken and freeze; a request in flight at reset SHALL be abandoned without a wait for imem_ready.

Verification
REQ-032 Reset, imem_ready=1 tied, rdata=addr|1 -> cycle 2 imem_addr=0; then Instruction=1,5,9 with PC_out=4,8,12, inst_valid=1 each cycle.
REQ-033 imem_ready=0 for 3 cycles at addr 8 -> imem_addr stays 8, outputs unchanged; on ready, Instruction=9, PC_out=12.
REQ-034 freeze=1 during a transfer at addr 16 -> SKID, imem_req=0, outputs hold; freeze drop -> Instruction=17, PC_out=20, next imem_addr=20.
REQ-035 branch_taken, branch_addr=0x100 while request at 0x20 stalled -> inst_valid=0; 0x20 data dropped when ready; next imem_addr=0x100; then Instruction=0x101, PC_out=0x104.
REQ-036 branch_taken and freeze together in SKID -> skid discarded, inst_valid=0, next imem_addr=branch_addr.
REQ-037 rst pulse mid-request at 0x40 -> next cycle imem_req=0, inst_valid=0, then imem_addr=RESET_PC.
